data_mem_arbiter: RTL
=====================

# data_mem_arbiter

Shares the single-port data memory between the pipeline MEM stage and the debug port, which reads and writes memory words for dump and load. The pipeline owns the port by default. Debug accesses are granted one memory cycle at a time, either when the pipeline leaves the port idle or after a bounded wait. Stealing a cycle from a busy pipeline asserts a stall. The block sits between the MEM-stage logic and the data memory instance, and drives all memory control, address and write-data lines.

## Interface
- ADDR_WIDTH, 11, data-memory word address width
- DATA_WIDTH, 32, data word width
- DBG_MAX_WAIT, 4, cycles a pending debug request waits behind a busy pipeline before forcing a steal (must be ≥1)

Ports:
- clock  in  1  system clock; all state updates on its rising edge
- reset_n  in  1  asynchronous, active-low reset
- pipe_mem_read  in  1  MEM-stage read request
- pipe_mem_write  in  1  MEM-stage write request
- pipe_address  in  ADDR_WIDTH  MEM-stage address
- pipe_wdata  in  DATA_WIDTH  MEM-stage write data, already truncated
- pipe_rdata  out  DATA_WIDTH  read data returned to the MEM stage
- pipe_stall  out  1  pipeline must hold the MEM stage and all earlier stages this cycle
- dbg_req  in  1  debug request; held until dbg_ack
- dbg_we  in  1  1 = write, 0 = read
- dbg_address  in  ADDR_WIDTH  debug address
- dbg_wdata  in  DATA_WIDTH  debug write data
- dbg_ack  out  1  one-cycle completion pulse
- dbg_rdata  out  DATA_WIDTH  registered debug read data; valid from the dbg_ack cycle until the next debug read completes
- mem_address  out  ADDR_WIDTH  to data memory
- mem_wdata  out  DATA_WIDTH  to data memory
- mem_read  out  1  to data memory
- mem_write  out  1  to data memory; memory writes on the clock edge when this is 1
- mem_rdata  in  DATA_WIDTH  from data memory; combinational from mem_address while mem_read = 1

## Operation
- FSM states: S_PIPE (reset state), S_DBG, S_ACK.
- S_PIPE:
  - mem_* outputs pass the pipe_* inputs through combinationally.
  - pipe_rdata = mem_rdata; pipe_stall = 0.
  - pipe_busy = pipe_mem_read | pipe_mem_write.
  - If dbg_req = 1 and (pipe_busy = 0 or wait_cnt = DBG_MAX_WAIT−1), go to S_DBG and latch dbg_we, dbg_address and dbg_wdata into internal registers.
  - Otherwise, if dbg_req = 1 and pipe_busy = 1, wait_cnt increments, saturating at DBG_MAX_WAIT−1.
  - If dbg_req = 0, wait_cnt clears to 0.
- S_DBG:
  - mem_address and mem_wdata come from the latched debug registers.
  - mem_write = latched we; mem_read = ~latched we.
  - pipe_stall = pipe_busy; pipe_rdata = 0. The pipeline write is not issued.
  - On the clock edge: if this is a read, dbg_rdata ← mem_rdata. wait_cnt ← 0. Go to S_ACK.
- S_ACK:
  - dbg_ack = 1 (registered, asserted for exactly this cycle).
  - The port behaves as in S_PIPE (pass-through, pipe_stall = 0).
  - dbg_req is ignored; the requester deasserts dbg_req after sampling dbg_ack.
  - The FSM always returns to S_PIPE.
- A debug write leaves dbg_rdata unchanged.
- pipe_mem_read and pipe_mem_write both 1 is illegal for the MEM stage. The arbiter passes both through unchanged.
- Reset (async, any state):
  - FSM → S_PIPE; wait_cnt = 0; dbg_ack = 0; dbg_rdata = 0; latched debug registers = 0.
  - A debug access in flight is dropped without an ack, and the requester re-issues it.
  - Outputs during reset: pipe_stall = 0, and mem_* follow the pipe_* inputs.

## Timing
- Debug latency with the pipeline idle: dbg_req seen at edge N → S_DBG in cycle N+1 → dbg_ack in cycle N+2. That is 2 cycles request-to-ack.
- Worst case with the pipeline busy: DBG_MAX_WAIT+1 cycles request-to-ack.
- At most one stall cycle per debug access.
- Back-to-back debug accesses need at least 3 cycles each (S_PIPE, S_DBG, S_ACK). The pipeline always gets at least 2 of every 3 cycles.
- The pipeline path is combinational (zero added latency) in S_PIPE and S_ACK.
- pipe_stall is combinational from state and the pipe_* requests. The MEM stage samples it in the same cycle.

## Test plan
- Reset release with the pipeline idle: a pipeline write of 0xDEADBEEF to address 0x010 followed by a read of 0x010 returns 0xDEADBEEF in the same cycle. pipe_stall stays 0 and dbg_ack stays 0.
- Debug read while the pipeline is idle: memory[0x123] = 0xCAFE0001, dbg_req with read at 0x123. Required: S_DBG on the next cycle, dbg_ack 2 cycles after the request, dbg_rdata = 0xCAFE0001, no stall.
- Starvation with DBG_MAX_WAIT = 4: the pipeline reads every cycle and dbg_req is set for a write of 0x55AA55AA to 0x7FF. Required: pipe_stall high for exactly 1 cycle, 4 cycles after the request. dbg_ack arrives 1 cycle later, and a pipeline read of 0x7FF afterwards returns 0x55AA55AA.
- Stolen write: a pipeline write to 0x020 coincides with the S_DBG cycle. Required: pipe_stall = 1 and memory[0x020] unchanged. When the pipeline re-presents the write in the following cycle, it completes.
- Async reset asserted in S_DBG: the debug write to 0x030 is dropped and no dbg_ack is issued. After release, the state is S_PIPE and dbg_rdata = 0. A re-issued request completes normally.
- Back-to-back debug reads of 0x001 and 0x002: the two acks are 3 cycles apart, and dbg_rdata updates on each ack cycle.

Source files
------------

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: shares the single-port data memory between the MEM stage and the debug port.
// The pipeline owns the port; debug takes one cycle when it is idle, or steals one after a bounded wait.
module data_mem_arbiter #(
    parameter int ADDR_WIDTH   = 11,
    parameter int DATA_WIDTH   = 32,
    parameter int DBG_MAX_WAIT = 4
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  pipe_mem_read,
    input  logic                  pipe_mem_write,
    input  logic [ADDR_WIDTH-1:0] pipe_address,
    input  logic [DATA_WIDTH-1:0] pipe_wdata,
    output logic [DATA_WIDTH-1:0] pipe_rdata,
    output logic                  pipe_stall,
    input  logic                  dbg_req,
    input  logic                  dbg_we,
    input  logic [ADDR_WIDTH-1:0] dbg_address,
    input  logic [DATA_WIDTH-1:0] dbg_wdata,
    output logic                  dbg_ack,
    output logic [DATA_WIDTH-1:0] dbg_rdata,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_read,
    output logic                  mem_write,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);
    localparam int WW = DBG_MAX_WAIT > 1 ? $clog2(DBG_MAX_WAIT) : 1;
    localparam logic [WW-1:0] WAIT_MAX = WW'(DBG_MAX_WAIT - 1);

    typedef enum logic [1:0] {S_PIPE, S_DBG, S_ACK} state_t;

    state_t                state_q, state_d;
    logic [WW-1:0]         wait_q, wait_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  pipe_busy, grant, dbg_sel;

    assign pipe_busy = pipe_mem_read | pipe_mem_write;
    assign grant     = dbg_req & (~pipe_busy | (wait_q == WAIT_MAX));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_PIPE;
            wait_q  <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            S_PIPE: begin
                wait_d = !dbg_req ? '0 : (pipe_busy && wait_q != WAIT_MAX) ? wait_q + 1'b1 : wait_q;
                if (grant) begin
                    state_d = S_DBG;
                    we_d    = dbg_we;
                    addr_d  = dbg_address;
                    wdata_d = dbg_wdata;
                end
            end
            S_DBG: begin
                state_d = S_ACK;
                wait_d  = '0;
                rdata_d = we_q ? rdata_q : mem_rdata;
            end
            default: state_d = S_PIPE;
        endcase
    end

    // Only S_DBG takes the port; S_ACK is already a pass-through cycle for the pipeline.
    always_comb begin
        dbg_sel     = state_q == S_DBG;
        mem_address = dbg_sel ? addr_q : pipe_address;
        mem_wdata   = dbg_sel ? wdata_q : pipe_wdata;
        mem_write   = dbg_sel ? we_q : pipe_mem_write;
        mem_read    = dbg_sel ? ~we_q : pipe_mem_read;
        pipe_rdata  = dbg_sel ? '0 : mem_rdata;
        pipe_stall  = dbg_sel & pipe_busy;
        dbg_ack     = state_q == S_ACK;
        dbg_rdata   = rdata_q;
    end
endmodule
